rf_wb_arbiter: RTL

- Write-side front end of the register file. It owns the single RF write port (RFWr/A3/WD) and merges two result sources:
  - the in-order pipeline writeback (WB stage);
  - a long-latency unit (divider/load-miss) through a small result FIFO.
- It also keeps a per-register pending scoreboard so decode can stall on RAW hazards against long-latency results still in flight.

---
 rtl/rf_wb_arbiter.sv | 135 +++++++++++++
 1 files changed

// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter: merges WB-stage writes with long-latency results queued in a small FIFO, and tracks pending long-latency destinations.
// Latency: a pipe write commits in the cycle it is presented; an LU result commits no earlier than the cycle after it is pushed.
// Backpressure: lu_ready drops while the FIFO is full; wb_stall holds the pipeline for one cycle after the FIFO head has waited STARVE_LIMIT cycles.
module rf_wb_arbiter #(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pipe_wr,
  input  logic [4:0]  pipe_rd,
  input  logic [31:0] pipe_wd,
  input  logic        lu_valid,
  output logic        lu_ready,
  input  logic [4:0]  lu_rd,
  input  logic [31:0] lu_wd,
  input  logic        issue_valid,
  input  logic [4:0]  issue_rd,
  input  logic [4:0]  q_rs1,
  input  logic [4:0]  q_rs2,
  output logic        busy1,
  output logic        busy2,
  output logic        wb_stall,
  output logic        RFWr,
  output logic [4:0]  A3,
  output logic [31:0] WD
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic [4:0]    r_mem_rd [DEPTH];
  logic [31:0]   r_mem_wd [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic [31:0]   r_busy;
  logic [SW-1:0] r_starve;
  logic          r_wb_stall;

  logic          w_fifo_ne;
  logic          w_push;
  logic          w_pipe_vld;
  logic          w_sel_fifo;
  logic          w_pop;
  logic [4:0]    w_head_rd;
  logic [31:0]   w_head_wd;
  logic [SW-1:0] w_starve_nxt;

  assign w_fifo_ne  = (r_count != '0);
  assign lu_ready   = (r_count != CW'(DEPTH));
  assign w_push     = lu_valid && lu_ready;
  assign w_head_rd  = r_mem_rd[r_rptr];
  assign w_head_wd  = r_mem_wd[r_rptr];
  // A stalled pipeline never gets the port; x0 writes are not requests.
  assign w_pipe_vld = pipe_wr && (pipe_rd != 5'd0) && !r_wb_stall;
  // FIFO wins when the pipe is stalled or idle.
  assign w_sel_fifo = w_fifo_ne && (r_wb_stall || !w_pipe_vld);
  assign w_pop      = w_sel_fifo && !rst;

  // Drive the single RF write port from the selected source; x0 FIFO entries pop silently.
  always_comb begin
    RFWr = 1'b0;
    A3   = 5'd0;
    WD   = 32'd0;
    if (!rst) begin
      if (w_sel_fifo) begin
        RFWr = (w_head_rd != 5'd0);
        A3   = w_head_rd;
        WD   = w_head_wd;
      end else if (w_pipe_vld) begin
        RFWr = 1'b1;
        A3   = pipe_rd;
        WD   = pipe_wd;
      end
    end
  end

  // Result storage; contents are meaningless once the count says empty, so no reset needed.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_rd[r_wptr] <= lu_rd;
      r_mem_wd[r_wptr] <= lu_wd;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at the power-of-2 depth.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Count cycles the head waits without popping; any pop or an empty FIFO restarts it.
  assign w_starve_nxt = (w_pop || !w_fifo_ne) ? '0 : r_starve + SW'(1);

  // Starvation counter and the one-cycle stall it triggers on reaching the limit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_starve   <= '0;
      r_wb_stall <= 1'b0;
    end else begin
      r_starve   <= w_starve_nxt;
      r_wb_stall <= (w_starve_nxt == SW'(STARVE_LIMIT));
    end
  end

  assign wb_stall = r_wb_stall;

  // Pending-write scoreboard: clear on FIFO commit, then set on issue so a same-register set wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy <= '0;
    end else begin
      if (w_pop && (w_head_rd != 5'd0)) r_busy[w_head_rd] <= 1'b0;
      if (issue_valid && (issue_rd != 5'd0)) r_busy[issue_rd] <= 1'b1;
    end
  end

  // A register committing from the FIFO this cycle is not busy: the RF bypass supplies WD.
  assign busy1 = (q_rs1 != 5'd0) && r_busy[q_rs1] && !(w_pop && (w_head_rd == q_rs1));
  assign busy2 = (q_rs2 != 5'd0) && r_busy[q_rs2] && !(w_pop && (w_head_rd == q_rs2));

endmodule
